// File: rtl/load_cell_smplr_if.sv
// load_cell_smplr_if: request/response link between the load-cell sampler and the shared SPI A2D master.
interface load_cell_smplr_if;
    logic        spi_req;
    logic [15:0] spi_cmd;
    logic        spi_done;
    logic [15:0] spi_rdata;
    modport master (output spi_req, spi_cmd, input spi_done, spi_rdata);
    modport slave (input spi_req, spi_cmd, output spi_done, spi_rdata);
endinterface

// File: rtl/load_cell_smplr.sv
// load_cell_smplr: periodically reads both load cells over the A2D link, clamps them and publishes them.
// Defining LD_FILTER_EN adds IIR smoothing of the published loads.
module load_cell_smplr #(
    parameter logic [15:0] SMPL_PER   = 16'd4096,
    parameter logic [11:0] TMO_CYC    = 12'd2048,
    parameter logic [2:0]  LFT_CH     = 3'd0,
    parameter logic [2:0]  RGHT_CH    = 3'd4,
    parameter int          FILT_SHIFT = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    load_cell_smplr_if.master io_spi,
    output logic [11:0]       o_lft_ld,
    output logic [11:0]       o_rght_ld,
    output logic              o_ld_vld,
    output logic              o_a2d_err
);
    typedef enum logic [2:0] {IDLE, L_SEL, L_RD, R_SEL, R_RD, UPD} state_t;
    state_t      r_state, w_state_nxt;
    logic [15:0] r_per, r_cmd;
    logic        r_pend, r_req, r_vld, r_err;
    logic [11:0] r_wd, r_lsmp, r_rsmp, r_lft, r_rght, w_lft_nxt, w_rght_nxt;
    logic        w_wrap, w_wait, w_tmo, w_start, w_req, w_cap_l, w_cap_r, w_upd;
    logic [2:0]  w_ch;
    logic        w_unused;

    // Anything above 12'h7FF would read as negative downstream.
    function automatic logic [11:0] clamp(input logic [11:0] s);
        return s[11] ? 12'h7FF : s;
    endfunction

    assign w_wrap = r_per == SMPL_PER - 16'd1;
    assign w_wait = r_state inside {L_SEL, L_RD, R_SEL, R_RD};
    // A done arriving on the last allowed cycle still counts as success.
    assign w_tmo  = w_wait && !io_spi.spi_done && r_wd == TMO_CYC - 12'd1;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) r_state <= IDLE;
        else r_state <= w_state_nxt;

    always_comb begin
        w_state_nxt = r_state;
        if (w_tmo) w_state_nxt = IDLE;
        else
            case (r_state)
                IDLE:    if (r_pend) w_state_nxt = L_SEL;
                L_SEL:   if (io_spi.spi_done) w_state_nxt = L_RD;
                L_RD:    if (io_spi.spi_done) w_state_nxt = R_SEL;
                R_SEL:   if (io_spi.spi_done) w_state_nxt = R_RD;
                R_RD:    if (io_spi.spi_done) w_state_nxt = UPD;
                default: w_state_nxt = IDLE;
            endcase
    end

    always_comb begin
        w_start = r_state == IDLE && r_pend;
        w_req   = w_start || (io_spi.spi_done && r_state inside {L_SEL, L_RD, R_SEL});
        w_ch    = r_state inside {IDLE, L_SEL} ? LFT_CH : RGHT_CH;
        w_cap_l = r_state == L_RD && io_spi.spi_done;
        w_cap_r = r_state == R_RD && io_spi.spi_done;
        w_upd   = r_state == UPD;
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            r_per  <= '0;
            r_pend <= 1'b0;
            r_req  <= 1'b0;
            r_cmd  <= '0;
            r_wd   <= '0;
            r_vld  <= 1'b0;
            r_err  <= 1'b0;
            r_lsmp <= '0;
            r_rsmp <= '0;
            r_lft  <= '0;
            r_rght <= '0;
        end else begin
            r_per  <= w_wrap ? 16'd0 : r_per + 16'd1;
            r_pend <= w_wrap || (r_pend && !w_start);
            r_req  <= w_req;
            r_vld  <= w_upd;
            r_err  <= w_tmo || (r_err && !w_upd);
            r_wd   <= w_req ? 12'd0 : r_wd + {11'd0, w_wait};
            if (w_req) r_cmd <= {2'b00, w_ch, 11'h000};
            if (w_cap_l) r_lsmp <= clamp(io_spi.spi_rdata[11:0]);
            if (w_cap_r) r_rsmp <= clamp(io_spi.spi_rdata[11:0]);
            if (w_upd) begin
                r_lft  <= w_lft_nxt;
                r_rght <= w_rght_nxt;
            end
        end

`ifdef LD_FILTER_EN
    logic r_primed;

    function automatic logic [11:0] iir(input logic [11:0] o, input logic [11:0] s);
        logic signed [12:0] d, y;
        d = $signed({1'b0, s}) - $signed({1'b0, o});
        y = $signed({1'b0, o}) + (d >>> FILT_SHIFT);
        return y[12] ? 12'h000 : (y[11] ? 12'h7FF : y[11:0]);
    endfunction

    // The first round after reset loads raw samples so the filter does not ramp up from zero.
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) r_primed <= 1'b0;
        else if (w_upd) r_primed <= 1'b1;

    assign w_lft_nxt  = r_primed ? iir(r_lft, r_lsmp) : r_lsmp;
    assign w_rght_nxt = r_primed ? iir(r_rght, r_rsmp) : r_rsmp;
    assign w_unused   = ^io_spi.spi_rdata[15:12];
`else
    assign w_lft_nxt  = r_lsmp;
    assign w_rght_nxt = r_rsmp;
    assign w_unused   = ^{io_spi.spi_rdata[15:12], FILT_SHIFT[0]};
`endif

    assign io_spi.spi_req  = r_req;
    assign io_spi.spi_cmd  = r_cmd;
    assign o_lft_ld        = r_lft;
    assign o_rght_ld       = r_rght;
    assign o_ld_vld        = r_vld;
    assign o_a2d_err       = r_err;
endmodule

// File: tb/tb_load_cell_smplr.sv
// tb_load_cell_smplr: random and directed A2D responder traffic checked every cycle against a round-level model.
module tb_load_cell_smplr;
    localparam int PER = 64;
    localparam int TMO = 100;
    localparam logic [2:0] LCH = 3'd0;
    localparam logic [2:0] RCH = 3'd4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [11:0] lft, rght;
    logic vld, err;
    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;

    load_cell_smplr_if spi();

    load_cell_smplr #(.SMPL_PER(16'(PER)), .TMO_CYC(12'(TMO)), .LFT_CH(LCH), .RGHT_CH(RCH), .FILT_SHIFT(2)) dut (
        .clk(clk), .rst_n(rst_n), .io_spi(spi),
        .o_lft_ld(lft), .o_rght_ld(rght), .o_ld_vld(vld), .o_a2d_err(err));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // SPI responder: done arrives lat cycles after each request.
    int lat = 12;
    bit rnd = 0;
    logic [11:0] l_val = 12'h300;
    logic [11:0] r_val = 12'h280;
    int stuck_req = -1;
    int stuck_cyc = 0;
    int nreq = 0;
    int s_cnt = 0;
    logic [2:0] s_ch = 3'd0;
    logic [15:0] cmd_log[$];

    initial begin
        spi.spi_done = 1'b0;
        spi.spi_rdata = 16'h0;
        forever begin
            @(negedge clk);
            spi.spi_done = 1'b0;
            spi.spi_rdata = 16'($urandom);
            if (!rst_n) s_cnt = 0;
            else begin
                if (s_cnt > 0) begin
                    s_cnt--;
                    if (s_cnt == 0) begin
                        spi.spi_done = 1'b1;
                        if (!rnd) spi.spi_rdata = {4'($urandom), s_ch == LCH ? l_val : r_val};
                    end
                end else if (rnd && $urandom_range(0, 39) == 0) spi.spi_done = 1'b1;
                if (spi.spi_req) begin
                    nreq++;
                    cmd_log.push_back(spi.spi_cmd);
                    s_ch = spi.spi_cmd[13:11];
                    if (nreq == stuck_req) begin
                        stuck_cyc = cyc;
                        s_cnt = 0;
                    end else
                        s_cnt = rnd ? ($urandom_range(0, 9) == 0 ? int'($urandom_range(95, 104)) : int'($urandom_range(1, 30))) : lat;
                end
            end
        end
    end

    // Reference model: a round is four transactions (sel L, read L, sel R, read R) then an update.
    logic e_req = 0, e_vld = 0, e_err = 0;
    logic [15:0] e_cmd = 0;
    logic [11:0] e_lft = 0, e_rght = 0, m_ls = 0, m_rs = 0;
    int m_cyc = 0, m_txn = 0, m_age = 0;
    bit m_pend = 0, m_wrap = 0;
`ifdef LD_FILTER_EN
    bit m_primed = 0;
    function automatic logic [11:0] f_upd(input logic [11:0] o, input logic [11:0] s, input bit primed);
        int d, y;
        if (!primed) return s;
        d = int'(s) - int'(o);
        y = int'(o) + (d < 0 ? -((-d + 3) / 4) : d / 4);
        return 12'(y < 0 ? 0 : (y > 2047 ? 2047 : y));
    endfunction
`endif

    function automatic logic [11:0] clampv(input logic [11:0] s);
        return s > 12'h7FF ? 12'h7FF : s;
    endfunction

    task automatic issue(input int k);
        e_req = 1'b1;
        e_cmd = {2'b00, k < 2 ? LCH : RCH, 11'h000};
        m_age = 0;
        m_txn = k + 1;
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            {e_req, e_vld, e_err, m_pend} = '0;
            e_cmd = '0; e_lft = '0; e_rght = '0; m_ls = '0; m_rs = '0;
            m_cyc = 0; m_txn = 0; m_age = 0;
`ifdef LD_FILTER_EN
            m_primed = 0;
`endif
        end else begin
            m_wrap = m_cyc % PER == PER - 1;
            m_cyc++;
            e_req = 1'b0;
            e_vld = 1'b0;
            if (m_txn == 0) begin
                if (m_pend) begin
                    m_pend = 0;
                    issue(0);
                end
            end else if (m_txn <= 4) begin
                if (spi.spi_done) begin
                    if (m_txn == 2) m_ls = clampv(spi.spi_rdata[11:0]);
                    if (m_txn == 4) m_rs = clampv(spi.spi_rdata[11:0]);
                    if (m_txn < 4) issue(m_txn);
                    else m_txn = 5;
                end else if (m_age == TMO - 1) begin
                    e_err = 1'b1;
                    m_txn = 0;
                end else m_age++;
            end else begin
`ifdef LD_FILTER_EN
                e_lft = f_upd(e_lft, m_ls, m_primed);
                e_rght = f_upd(e_rght, m_rs, m_primed);
                m_primed = 1;
`else
                e_lft = m_ls;
                e_rght = m_rs;
`endif
                e_vld = 1'b1;
                e_err = 1'b0;
                m_txn = 0;
            end
            if (m_wrap) m_pend = 1;
        end
    end

    always @(negedge clk) begin
        chk("spi_req", 32'(spi.spi_req), 32'(e_req));
        chk("spi_cmd", 32'(spi.spi_cmd), 32'(e_cmd));
        chk("lft_ld", 32'(lft), 32'(e_lft));
        chk("rght_ld", 32'(rght), 32'(e_rght));
        chk("ld_vld", 32'(vld), 32'(e_vld));
        chk("a2d_err", 32'(err), 32'(e_err));
    end

    task automatic wait_vld(input string nm, input int bound, output int t);
        t = -1;
        for (int i = 0; i < bound && t < 0; i++) begin
            @(negedge clk);
            if (vld) t = cyc;
        end
        n_chk++;
        if (t < 0) begin
            n_fail++;
            $display("FAIL %s: got no ld_vld, expected one within %0d cycles", nm, bound);
        end
    endtask

    task automatic wait_err(input string nm, input int bound, output int t, output int nv);
        t = -1;
        nv = 0;
        for (int i = 0; i < bound && t < 0; i++) begin
            @(negedge clk);
            if (vld) nv++;
            if (err) t = cyc;
        end
        n_chk++;
        if (t < 0) begin
            n_fail++;
            $display("FAIL %s: got no a2d_err, expected one within %0d cycles", nm, bound);
        end
    endtask

    task automatic pulse_rst(input int n);
        @(posedge clk);
        #2 rst_n = 1'b0;
        repeat (n) @(posedge clk);
        #2 rst_n = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: got no end of test, expected it before 1 ms");
        $fatal(1, "simulation time limit reached");
    end

    initial begin
        int t0, t1, t2, nv, n0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        chk("rst_lft", 32'(lft), 32'h0);
        chk("rst_rght", 32'(rght), 32'h0);
        chk("rst_err", 32'(err), 32'h0);
        chk("rst_cmd", 32'(spi.spi_cmd), 32'h0);

        wait_vld("p1_first", 200, t0);
        chk("p1_ncmd", 32'(cmd_log.size()), 32'd4);
        chk("p1_cmd0", 32'(cmd_log[0]), 32'h0000);
        chk("p1_cmd1", 32'(cmd_log[1]), 32'h0000);
        chk("p1_cmd2", 32'(cmd_log[2]), 32'h2000);
        chk("p1_cmd3", 32'(cmd_log[3]), 32'h2000);
        chk("p1_lft", 32'(lft), 32'h300);
        chk("p1_rght", 32'(rght), 32'h280);
        @(negedge clk);
        chk("p1_vld_single", 32'(vld), 32'h0);
        wait_vld("p1_second", 200, t1);
        chk("p1_period", 32'(t1 - t0), 32'd64);

`ifndef LD_FILTER_EN
        l_val = 12'hF00; r_val = 12'h7FF;
        wait_vld("p2_a", 200, t0);
        chk("p2_clamp_f00", 32'(lft), 32'h7FF);
        chk("p2_keep_7ff", 32'(rght), 32'h7FF);
        l_val = 12'h7FF; r_val = 12'h800;
        wait_vld("p2_b", 200, t0);
        chk("p2_keep_7ff_l", 32'(lft), 32'h7FF);
        chk("p2_clamp_800", 32'(rght), 32'h7FF);
`endif
        l_val = 12'h7FE; r_val = 12'h000;
        wait_vld("p2_c", 200, t0);
`ifndef LD_FILTER_EN
        chk("p2_lft_7fe", 32'(lft), 32'h7FE);
        chk("p2_rght_0", 32'(rght), 32'h000);
`endif

        stuck_req = nreq + 2;
        wait_err("p3_tmo", 400, t0, nv);
        chk("p3_tmo_delay", 32'(t0 - stuck_cyc), 32'(TMO));
        chk("p3_no_vld", 32'(nv), 32'd0);
`ifndef LD_FILTER_EN
        chk("p3_lft_kept", 32'(lft), 32'h7FE);
`endif
        stuck_req = -1;
        wait_vld("p3_recover", 300, t0);
        chk("p3_err_clr", 32'(err), 32'h0);

        lat = TMO - 1;
        wait_vld("p3_lat99", 600, t0);
        chk("p3_lat99_err", 32'(err), 32'h0);
        lat = TMO;
        wait_err("p3_lat100", 300, t0, nv);
        chk("p3_lat100_no_vld", 32'(nv), 32'd0);
        lat = 12;
        wait_vld("p3_back", 300, t0);

        lat = 90;
        wait_vld("p4_a", 800, t0);
        wait_vld("p4_b", 800, t1);
        wait_vld("p4_c", 800, t2);
        chk("p4_period_a", 32'(t1 - t0), 32'd366);
        chk("p4_period_b", 32'(t2 - t1), 32'd366);

        lat = 12; l_val = 12'h123; r_val = 12'h456;
        wait_vld("p5_sync", 800, t0);
        n0 = nreq;
        for (int i = 0; i < 200 && nreq < n0 + 4; i++) @(negedge clk);
        chk("p5_in_r_rd", 32'(nreq - n0), 32'd4);
        @(posedge clk);
        #2 rst_n = 1'b0;
        @(negedge clk);
        chk("p5_rst_lft", 32'(lft), 32'h0);
        chk("p5_rst_rght", 32'(rght), 32'h0);
        chk("p5_rst_req", 32'(spi.spi_req), 32'h0);
        chk("p5_rst_cmd", 32'(spi.spi_cmd), 32'h0);
        @(posedge clk);
        #2 rst_n = 1'b1;
        wait_vld("p5_clean", 200, t0);
        chk("p5_lft", 32'(lft), 32'h123);
        chk("p5_rght", 32'(rght), 32'h456);

`ifdef LD_FILTER_EN
        pulse_rst(2);
        l_val = 12'h400;
        wait_vld("p6_a", 200, t0);
        chk("p6_prime", 32'(lft), 32'h400);
        l_val = 12'h000;
        wait_vld("p6_b", 200, t0);
        chk("p6_step1", 32'(lft), 32'h300);
        wait_vld("p6_c", 200, t0);
        chk("p6_step2", 32'(lft), 32'h240);
`endif

        rnd = 1;
        repeat (1500) @(negedge clk);
        pulse_rst(2);
        repeat (1500) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
